pc_fetch_seq: RTL

- Multi-cycle instruction-fetch sequencer for the MIPS core.
- Owns the architectural PC register and fetches from instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Applies branch/jump redirects using the NPC target encoding: PLUS4, BRANCH, JUMP.
- Sits between the instruction memory and the decode/execute stages, replacing free-running PC update with a sequenced one.

---
 rtl/pc_fetch_seq_if.sv | 30 +++
 rtl/pc_fetch_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq_if.sv
// rtl/pc_fetch_seq_if.sv - fetch sequencer bus: redirect, imem req/ack and decode valid/ready
interface pc_fetch_seq_if;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic [31:0] redir_rs;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc;
  logic        err_timeout;

  modport master (
    input  redir_valid, redir_op, redir_pc, redir_imm, redir_rs,
    input  imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc, err_timeout
  );

  modport slave (
    output redir_valid, redir_op, redir_pc, redir_imm, redir_rs,
    output imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc, err_timeout
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - multi-cycle instruction fetch sequencer owning the PC, with NPC redirects
// Optional feature macro NPC_JR_EN: redir_op 2'b11 selects the JR register target.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_seq_if.master  bus
);
  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   ipc_q, ipc_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   p4, target;
  logic          unused_rs;

  assign unused_rs = ^bus.redir_rs;

  always_comb begin
    p4     = bus.redir_pc + 32'd4;
    target = p4;
    case (bus.redir_op)
      2'b01:   target = p4 + {{14{bus.redir_imm[15]}}, bus.redir_imm[15:0], 2'b00};
      2'b10:   target = {p4[31:28], bus.redir_imm, 2'b00};
`ifdef NPC_JR_EN
      2'b11:   target = {bus.redir_rs[31:2], 2'b00};
`else
      2'b11:   target = p4;
`endif
      default: target = p4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    cnt_d   = '0;
    cnt_inc = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redir_valid) pc_d = target;
      end
      S_REQ: begin
        if (bus.redir_valid) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = bus.imem_ack ? S_REQ : S_DROP;
        end else if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.redir_valid) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // A redirect while draining keeps us draining; only the ack releases the new pc.
        if (bus.redir_valid) pc_d = target;
        else if (bus.imem_ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ) || (state_d == S_DROP);
    if (state_d == S_REQ) addr_d = pc_d;

    // The request is never abandoned on timeout; the counter just rearms.
    if (req_q && !bus.imem_ack && req_d) begin
      if (cnt_inc == CW'(FETCH_TIMEOUT)) err_d = 1'b1;
      else                                 cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.inst_valid  = valid_q;
  assign bus.inst        = inst_q;
  assign bus.inst_pc     = ipc_q;
  assign bus.pc          = pc_q;
  assign bus.err_timeout = err_q;
endmodule
